// File: rtl/dpwm_pkg.sv
// dpwm_pkg: shared definitions for the DPWM sequencer.
//  - FSM state encoding (IDLE=0, RAMP=1, RUN=2, FAULT=3)
//  - default word resolution
//  - saturating min / add helpers, evaluated on a wide word so any
//    RESOLUTION up to DPWM_WMAX-1 bits is handled without overflow.
package dpwm_pkg;

    localparam int unsigned DPWM_RESOLUTION_DEFAULT = 32'd12;
    localparam int unsigned DPWM_WMAX               = 32'd32;

    typedef logic [DPWM_WMAX-1:0] dpwm_word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FAULT = 3'd3
    } dpwm_state_e;

    // Smaller of two unsigned words.
    function automatic dpwm_word_t dpwm_min(input dpwm_word_t a, input dpwm_word_t b);
        dpwm_word_t r;
        if (a < b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

    // a + b, saturated at limit; the sum carries one extra bit so it cannot wrap.
    function automatic dpwm_word_t dpwm_sat_add(input dpwm_word_t a,
                                                input dpwm_word_t b,
                                                input dpwm_word_t limit);
        logic [DPWM_WMAX:0] sum;
        dpwm_word_t         r;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, limit}) begin
            r = limit;
        end else begin
            r = sum[DPWM_WMAX-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/dpwm_period_tracker.sv
// dpwm_period_tracker: local mirror of the pwm_generator period counter.
// The count is held at 0 while the generator is in reset, otherwise it runs
// 0..fs and wraps, where fs = all-ones - frequency_select currently in force.
// It flags the boundary cycle (count == fs) for the sequencer and produces a
// registered period_start pulse that lines up with the generator's count 0.
module dpwm_period_tracker
    import dpwm_pkg::*;
#(
    parameter int unsigned RESOLUTION = DPWM_RESOLUTION_DEFAULT
) (
    input  logic                  hf_clock,
    input  logic                  reset_n,
    input  logic [RESOLUTION-1:0] frequency_select,
    input  logic                  pwm_reset,
    input  logic                  pwm_reset_next,
    output logic                  boundary,
    output logic                  period_start
);

    localparam logic [RESOLUTION-1:0] ZERO_W = {RESOLUTION{1'b0}};
    localparam logic [RESOLUTION-1:0] ONE_W  = {{(RESOLUTION-1){1'b0}}, 1'b1};

    logic [RESOLUTION-1:0] fs_s;
    logic [RESOLUTION-1:0] count_r;
    logic [RESOLUTION-1:0] count_next_s;
    logic                  at_end_s;
    logic                  period_start_r;

    assign fs_s     = ~frequency_select;
    assign at_end_s = (count_r >= fs_s);
    assign boundary = (!pwm_reset) && at_end_s;

    // Next mirror count: held while the generator is reset, wraps after fs.
    always_comb begin
        count_next_s = count_r;
        if (pwm_reset) begin
            count_next_s = ZERO_W;
        end else if (at_end_s) begin
            count_next_s = ZERO_W;
        end else begin
            count_next_s = count_r + ONE_W;
        end
    end

    // Mirror counter and period_start register (pulse aligned with count 0).
    always_ff @(posedge hf_clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r        <= ZERO_W;
            period_start_r <= 1'b0;
        end else begin
            count_r        <= count_next_s;
            period_start_r <= (!pwm_reset_next) && (count_next_s == ZERO_W);
        end
    end

    assign period_start = period_start_r;

endmodule

// File: rtl/dpwm_sequencer.sv
// dpwm_sequencer: controller for one pwm_generator.
// Owns highD / lowD / frequency_select / reset of the generator and sequences
// IDLE -> (RAMP) -> RUN, with FAULT shutdown. Settings change only at a
// sawtooth period boundary (or on state entry), so a running period is never
// disturbed. lowD trails highD by the dead time, clamped to the period.
// Optional feature macro: DPWM_SOFTSTART_EN (present: soft-start RAMP state;
// absent: IDLE goes straight to RUN at the clamped duty, RAMP_STEP unused).
module dpwm_sequencer
    import dpwm_pkg::*;
#(
    parameter int unsigned RESOLUTION = DPWM_RESOLUTION_DEFAULT,
    parameter int unsigned RAMP_STEP  = 32'd1
) (
    input  logic                  hf_clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  fault,
    input  logic                  clear_fault,
    input  logic [RESOLUTION-1:0] duty_target,
    input  logic [RESOLUTION-1:0] dead_time,
    input  logic [RESOLUTION-1:0] freq_sel_in,
    output logic [RESOLUTION-1:0] highD,
    output logic [RESOLUTION-1:0] lowD,
    output logic [RESOLUTION-1:0] frequency_select,
    output logic                  pwm_reset,
    output logic                  period_start,
    output logic                  fault_latched,
    output logic [2:0]            state
);

    localparam logic [RESOLUTION-1:0] ZERO_W = {RESOLUTION{1'b0}};

    // RESOLUTION-wide wrappers around the package helpers.
    function automatic logic [RESOLUTION-1:0] rmin(input logic [RESOLUTION-1:0] a,
                                                   input logic [RESOLUTION-1:0] b);
        return RESOLUTION'(dpwm_min(dpwm_word_t'(a), dpwm_word_t'(b)));
    endfunction

    function automatic logic [RESOLUTION-1:0] rsat(input logic [RESOLUTION-1:0] a,
                                                   input logic [RESOLUTION-1:0] b,
                                                   input logic [RESOLUTION-1:0] limit);
        return RESOLUTION'(dpwm_sat_add(dpwm_word_t'(a), dpwm_word_t'(b), dpwm_word_t'(limit)));
    endfunction

    dpwm_state_e           state_r;
    dpwm_state_e           state_next_s;
    logic [RESOLUTION-1:0] high_r;
    logic [RESOLUTION-1:0] high_next_s;
    logic [RESOLUTION-1:0] low_r;
    logic [RESOLUTION-1:0] low_next_s;
    logic [RESOLUTION-1:0] fsel_r;
    logic [RESOLUTION-1:0] fsel_next_s;
    logic                  pwm_reset_r;
    logic                  pwm_reset_next_s;
    logic                  fault_latched_r;

    logic                  boundary_s;

    // Settings derived from the live inputs; they only take effect when
    // the FSM loads them (boundary or state entry), so fs comes from
    // freq_sel_in, which is loaded in the same cycle.
    logic [RESOLUTION-1:0] fs_in_s;
    logic [RESOLUTION-1:0] dt_s;
    logic [RESOLUTION-1:0] dmax_s;
    logic [RESOLUTION-1:0] dclamp_s;
    logic [RESOLUTION-1:0] low_dclamp_s;

    assign fs_in_s      = ~freq_sel_in;
    assign dt_s         = rmin(dead_time, fs_in_s);
    assign dmax_s       = fs_in_s - dt_s;
    assign dclamp_s     = rmin(duty_target, dmax_s);
    assign low_dclamp_s = rsat(dclamp_s, dt_s, fs_in_s);

`ifdef DPWM_SOFTSTART_EN
    localparam logic [RESOLUTION-1:0] RAMP_STEP_W = RESOLUTION'(RAMP_STEP);

    logic [RESOLUTION-1:0] ramp_s;
    logic [RESOLUTION-1:0] low_ramp_s;

    assign ramp_s     = rsat(high_r, RAMP_STEP_W, dclamp_s);
    assign low_ramp_s = rsat(ramp_s, dt_s, fs_in_s);
`endif

    dpwm_period_tracker #(
        .RESOLUTION (RESOLUTION)
    ) u_tracker (
        .hf_clock         (hf_clock),
        .reset_n          (reset_n),
        .frequency_select (fsel_r),
        .pwm_reset        (pwm_reset_r),
        .pwm_reset_next   (pwm_reset_next_s),
        .boundary         (boundary_s),
        .period_start     (period_start)
    );

    // Next-state and next-output logic; fault overrides everything else.
    always_comb begin
        state_next_s     = state_r;
        high_next_s      = high_r;
        low_next_s       = low_r;
        fsel_next_s      = fsel_r;
        pwm_reset_next_s = pwm_reset_r;

        if (fault) begin
            state_next_s     = ST_FAULT;
            pwm_reset_next_s = 1'b1;
            high_next_s      = ZERO_W;
            low_next_s       = ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pwm_reset_next_s = 1'b1;
                    high_next_s      = ZERO_W;
                    low_next_s       = ZERO_W;
                    if (enable) begin
                        pwm_reset_next_s = 1'b0;
                        fsel_next_s      = freq_sel_in;
`ifdef DPWM_SOFTSTART_EN
                        state_next_s     = ST_RAMP;
                        high_next_s      = ZERO_W;
                        low_next_s       = dt_s;
`else
                        state_next_s     = ST_RUN;
                        high_next_s      = dclamp_s;
                        low_next_s       = low_dclamp_s;
`endif
                    end else begin
                        state_next_s     = ST_IDLE;
                    end
                end

`ifdef DPWM_SOFTSTART_EN
                ST_RAMP: begin
                    if (!enable) begin
                        state_next_s     = ST_IDLE;
                        pwm_reset_next_s = 1'b1;
                        high_next_s      = ZERO_W;
                        low_next_s       = ZERO_W;
                    end else if (boundary_s) begin
                        fsel_next_s = freq_sel_in;
                        if (duty_target < high_r) begin
                            // Target fell below the ramp: jump straight to it.
                            state_next_s = ST_RUN;
                            high_next_s  = dclamp_s;
                            low_next_s   = low_dclamp_s;
                        end else begin
                            high_next_s = ramp_s;
                            low_next_s  = low_ramp_s;
                            if (ramp_s == dclamp_s) begin
                                state_next_s = ST_RUN;
                            end else begin
                                state_next_s = ST_RAMP;
                            end
                        end
                    end else begin
                        state_next_s = ST_RAMP;
                    end
                end
`endif

                ST_RUN: begin
                    if (!enable) begin
                        state_next_s     = ST_IDLE;
                        pwm_reset_next_s = 1'b1;
                        high_next_s      = ZERO_W;
                        low_next_s       = ZERO_W;
                    end else if (boundary_s) begin
                        fsel_next_s = freq_sel_in;
                        high_next_s = dclamp_s;
                        low_next_s  = low_dclamp_s;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end

                ST_FAULT: begin
                    pwm_reset_next_s = 1'b1;
                    high_next_s      = ZERO_W;
                    low_next_s       = ZERO_W;
                    // Release needs an explicit clear with switching not requested.
                    if (clear_fault && !enable) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_FAULT;
                    end
                end

                default: begin
                    state_next_s     = ST_IDLE;
                    pwm_reset_next_s = 1'b1;
                    high_next_s      = ZERO_W;
                    low_next_s       = ZERO_W;
                end
            endcase
        end
    end

    // State and generator-facing output registers.
    always_ff @(posedge hf_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            high_r          <= ZERO_W;
            low_r           <= ZERO_W;
            fsel_r          <= ZERO_W;
            pwm_reset_r     <= 1'b1;
            fault_latched_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            high_r          <= high_next_s;
            low_r           <= low_next_s;
            fsel_r          <= fsel_next_s;
            pwm_reset_r     <= pwm_reset_next_s;
            fault_latched_r <= (state_next_s == ST_FAULT);
        end
    end

    assign highD            = high_r;
    assign lowD             = low_r;
    assign frequency_select = fsel_r;
    assign pwm_reset        = pwm_reset_r;
    assign fault_latched    = fault_latched_r;
    assign state            = state_r;

endmodule

// File: tb/tb_dpwm_sequencer.sv
// tb_dpwm_sequencer: directed self-checking bench for dpwm_sequencer.
// freq_sel_in = 4086 (fs = 9, 10-cycle period), dead_time = 2, RAMP_STEP = 1.
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_dpwm_sequencer;

    logic        hf_clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        fault;
    logic        clear_fault;
    logic [11:0] duty_target;
    logic [11:0] dead_time;
    logic [11:0] freq_sel_in;
    logic [11:0] highD;
    logic [11:0] lowD;
    logic [11:0] frequency_select;
    logic        pwm_reset;
    logic        period_start;
    logic        fault_latched;
    logic [2:0]  state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 hf_clock = ~hf_clock;

    dpwm_sequencer #(
        .RESOLUTION (12),
        .RAMP_STEP  (1)
    ) dut (
        .hf_clock         (hf_clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .fault            (fault),
        .clear_fault      (clear_fault),
        .duty_target      (duty_target),
        .dead_time        (dead_time),
        .freq_sel_in      (freq_sel_in),
        .highD            (highD),
        .lowD             (lowD),
        .frequency_select (frequency_select),
        .pwm_reset        (pwm_reset),
        .period_start     (period_start),
        .fault_latched    (fault_latched),
        .state            (state)
    );

    task automatic test_reset();
        enable      = 1'b0;
        fault       = 1'b0;
        clear_fault = 1'b0;
        duty_target = 12'd0;
        dead_time   = 12'd2;
        freq_sel_in = 12'd4086;
        reset_n     = 1'b1;
        #1 reset_n  = 1'b0;
        #1;
        total_cnt++;
        if ({highD, lowD, frequency_select} !== 36'd0)
            $display("FAIL reset_duty: high=%0d low=%0d fsel=%0d expected 0/0/0", highD, lowD, frequency_select);
        else pass_cnt++;
        total_cnt++;
        if ({pwm_reset, period_start, fault_latched, state} !== 6'b100_000)
            $display("FAIL reset_ctrl: pwm_reset=%0b period_start=%0b fault_latched=%0b state=%0d expected 1/0/0/0",
                     pwm_reset, period_start, fault_latched, state);
        else pass_cnt++;
        repeat (2) @(negedge hf_clock);
        reset_n = 1'b1;
        @(negedge hf_clock);
        total_cnt++;
        if ({pwm_reset, period_start, state} !== 5'b10_000)
            $display("FAIL idle_hold: pwm_reset=%0b period_start=%0b state=%0d expected 1/0/0", pwm_reset, period_start, state);
        else pass_cnt++;
    endtask

    // Start-up with duty_target = 6: ends on a falling edge where count == 0, highD == 6, RUN.
    task automatic test_start();
        logic [2:0] exp_state;
        enable      = 1'b1;
        duty_target = 12'd6;
        @(negedge hf_clock);
        total_cnt++;
        if ({pwm_reset, period_start, frequency_select} !== {1'b0, 1'b1, 12'd4086})
            $display("FAIL start_first: pwm_reset=%0b period_start=%0b fsel=%0d expected 0/1/4086",
                     pwm_reset, period_start, frequency_select);
        else pass_cnt++;
`ifdef DPWM_SOFTSTART_EN
        total_cnt++;
        if ({state, highD, lowD} !== {3'd1, 12'd0, 12'd2})
            $display("FAIL ramp_entry: state=%0d high=%0d low=%0d expected 1/0/2", state, highD, lowD);
        else pass_cnt++;
        for (int k = 1; k <= 6; k++) begin
            repeat (10) @(negedge hf_clock);
            exp_state = (k == 6) ? 3'd2 : 3'd1;
            total_cnt++;
            if ({period_start, state, highD, lowD} !== {1'b1, exp_state, 12'(k), 12'(k + 2)})
                $display("FAIL ramp_step%0d: period_start=%0b state=%0d high=%0d low=%0d expected 1/%0d/%0d/%0d",
                         k, period_start, state, highD, lowD, exp_state, k, k + 2);
            else pass_cnt++;
        end
`else
        exp_state = 3'd2;
        total_cnt++;
        if ({state, highD, lowD} !== {exp_state, 12'd6, 12'd8})
            $display("FAIL direct_entry: state=%0d high=%0d low=%0d expected 2/6/8", state, highD, lowD);
        else pass_cnt++;
        repeat (9) @(negedge hf_clock);
        total_cnt++;
        if ({period_start, highD, lowD} !== {1'b0, 12'd6, 12'd8})
            $display("FAIL period_mid: period_start=%0b high=%0d low=%0d expected 0/6/8", period_start, highD, lowD);
        else pass_cnt++;
        @(negedge hf_clock);
        total_cnt++;
        if ({period_start, state, highD} !== {1'b1, 3'd2, 12'd6})
            $display("FAIL period_len: period_start=%0b state=%0d high=%0d expected 1/2/6", period_start, state, highD);
        else pass_cnt++;
`endif
    endtask

    // Mid-period duty change only lands after the next boundary.
    task automatic test_duty_change();
        repeat (4) @(negedge hf_clock);
        duty_target = 12'd3;
        repeat (5) @(negedge hf_clock);
        total_cnt++;
        if ({period_start, highD, lowD} !== {1'b0, 12'd6, 12'd8})
            $display("FAIL duty_hold: period_start=%0b high=%0d low=%0d expected 0/6/8", period_start, highD, lowD);
        else pass_cnt++;
        @(negedge hf_clock);
        total_cnt++;
        if ({period_start, highD, lowD} !== {1'b1, 12'd3, 12'd5})
            $display("FAIL duty_apply: period_start=%0b high=%0d low=%0d expected 1/3/5", period_start, highD, lowD);
        else pass_cnt++;
    endtask

    // Clamp limits: dmax = 9 - 2 = 7; lowD capped at fs = 9; zero duty keeps dead time.
    task automatic test_saturation();
        duty_target = 12'd9;
        repeat (10) @(negedge hf_clock);
        total_cnt++;
        if ({state, highD, lowD} !== {3'd2, 12'd7, 12'd9})
            $display("FAIL sat_high: state=%0d high=%0d low=%0d expected 2/7/9", state, highD, lowD);
        else pass_cnt++;
        duty_target = 12'd0;
        repeat (10) @(negedge hf_clock);
        total_cnt++;
        if ({highD, lowD} !== {12'd0, 12'd2})
            $display("FAIL sat_zero: high=%0d low=%0d expected 0/2", highD, lowD);
        else pass_cnt++;
        duty_target = 12'd5;
        repeat (10) @(negedge hf_clock);
        total_cnt++;
        if ({highD, lowD} !== {12'd5, 12'd7})
            $display("FAIL run_five: high=%0d low=%0d expected 5/7", highD, lowD);
        else pass_cnt++;
    endtask

    // enable low mid-period stops on the next cycle without waiting for a boundary.
    task automatic test_stop();
        repeat (3) @(negedge hf_clock);
        enable = 1'b0;
        @(negedge hf_clock);
        total_cnt++;
        if ({state, pwm_reset, period_start, highD, lowD} !== {3'd0, 1'b1, 1'b0, 12'd0, 12'd0})
            $display("FAIL stop: state=%0d pwm_reset=%0b period_start=%0b high=%0d low=%0d expected 0/1/0/0/0",
                     state, pwm_reset, period_start, highD, lowD);
        else pass_cnt++;
    endtask

    task automatic test_fault();
        enable      = 1'b1;
        duty_target = 12'd4;
        repeat (12) @(negedge hf_clock);
`ifdef DPWM_SOFTSTART_EN
        total_cnt++;
        if ({state, highD} !== {3'd1, 12'd1})
            $display("FAIL pre_fault: state=%0d high=%0d expected 1/1", state, highD);
        else pass_cnt++;
`else
        total_cnt++;
        if ({state, highD} !== {3'd2, 12'd4})
            $display("FAIL pre_fault: state=%0d high=%0d expected 2/4", state, highD);
        else pass_cnt++;
`endif
        fault = 1'b1;
        @(negedge hf_clock);
        total_cnt++;
        if ({state, pwm_reset, fault_latched, highD, lowD} !== {3'd3, 1'b1, 1'b1, 12'd0, 12'd0})
            $display("FAIL fault_entry: state=%0d pwm_reset=%0b latched=%0b high=%0d low=%0d expected 3/1/1/0/0",
                     state, pwm_reset, fault_latched, highD, lowD);
        else pass_cnt++;
        fault = 1'b0;
        enable = 1'b0;
        @(negedge hf_clock);
        total_cnt++;
        if ({state, fault_latched} !== {3'd3, 1'b1})
            $display("FAIL fault_sticky: state=%0d latched=%0b expected 3/1", state, fault_latched);
        else pass_cnt++;
        enable      = 1'b1;
        clear_fault = 1'b1;
        @(negedge hf_clock);
        total_cnt++;
        if ({state, fault_latched, pwm_reset} !== {3'd3, 1'b1, 1'b1})
            $display("FAIL clear_with_enable: state=%0d latched=%0b pwm_reset=%0b expected 3/1/1",
                     state, fault_latched, pwm_reset);
        else pass_cnt++;
        enable = 1'b0;
        @(negedge hf_clock);
        clear_fault = 1'b0;
        total_cnt++;
        if ({state, fault_latched, pwm_reset} !== {3'd0, 1'b0, 1'b1})
            $display("FAIL clear_exit: state=%0d latched=%0b pwm_reset=%0b expected 0/0/1",
                     state, fault_latched, pwm_reset);
        else pass_cnt++;
    endtask

    // Reset asserted mid-RUN, between clock edges, must clear outputs at once.
    task automatic test_async_reset();
        enable      = 1'b1;
        duty_target = 12'd6;
        repeat (80) @(negedge hf_clock);
        total_cnt++;
        if ({state, highD, pwm_reset} !== {3'd2, 12'd6, 1'b0})
            $display("FAIL pre_reset_run: state=%0d high=%0d pwm_reset=%0b expected 2/6/0", state, highD, pwm_reset);
        else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({highD, lowD, frequency_select} !== 36'd0)
            $display("FAIL async_reset_duty: high=%0d low=%0d fsel=%0d expected 0/0/0", highD, lowD, frequency_select);
        else pass_cnt++;
        total_cnt++;
        if ({pwm_reset, period_start, fault_latched, state} !== 6'b100_000)
            $display("FAIL async_reset_ctrl: pwm_reset=%0b period_start=%0b latched=%0b state=%0d expected 1/0/0/0",
                     pwm_reset, period_start, fault_latched, state);
        else pass_cnt++;
        enable = 1'b0;
        @(negedge hf_clock);
        reset_n = 1'b1;
        @(negedge hf_clock);
    endtask

    initial begin
        test_reset();
        test_start();
        test_duty_change();
        test_saturation();
        test_stop();
        test_fault();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dpwm_sequencer.md
# dpwm_sequencer

Controller that drives one `pwm_generator` instance: it owns the generator's `highD`, `lowD`, `frequency_select` and `reset` inputs, sequences start-up, optional soft-start, run and fault shutdown, and applies every setting change only at a sawtooth period boundary. It keeps a local mirror of the generator's period counter so boundary updates never glitch a running period, and it inserts a trailing dead time between HPWM falling and LPWM rising.

## Interface
- `RESOLUTION`, 12, width of duty, dead-time and frequency words (must match the generator).
- `RAMP_STEP`, 1, duty increment per period during soft-start.
- `hf_clock`  in  1  single clock, shared with the generator.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; 1 requests switching, 0 requests stop.
- `fault`  in  1  level; an external fault, sampled synchronously.
- `clear_fault`  in  1  pulse; releases the FAULT state.
- `duty_target`  in  RESOLUTION  requested high-side on-count.
- `dead_time`  in  RESOLUTION  gap in counts between HPWM fall and LPWM rise.
- `freq_sel_in`  in  RESOLUTION  requested `frequency_select`.
- `highD`, `lowD`, `frequency_select`  out  RESOLUTION  registered, to the generator.
- `pwm_reset`  out  1  registered, to the generator's `reset`.
- `period_start`  out  1  one-cycle pulse when the mirror count is 0 and `pwm_reset`=0.
- `fault_latched`  out  1  high while in FAULT.
- `state`  out  3  current FSM state encoding.

## Operation
- Arithmetic:
  - fs = all-ones − `frequency_select`.
  - dt = min(`dead_time`, fs).
  - dmax = fs − dt.
  - dclamp = min(`duty_target`, dmax).
  - `lowD` = min(`highD` + dt, fs), with the sum computed at RESOLUTION+1 bits.
  - Ramp sum is computed at RESOLUTION+1 bits and saturates at dclamp.
- Mirror counter:
  - Held at 0 while `pwm_reset`=1.
  - Otherwise it counts 0..fs and wraps to 0.
  - The boundary is the cycle where count==fs.
- Boundary update: `highD`, `lowD` and `frequency_select` load only on a boundary cycle, except on state entry. `freq_sel_in` and `duty_target` are sampled on that cycle and are ignored mid-period.
- FSM states: IDLE, RAMP, RUN, FAULT.
- IDLE:
  - `pwm_reset`=1 and `highD`=0.
  - When `enable`=1 and `fault`=0, go to RAMP. On entry load `frequency_select` from `freq_sel_in`, set `highD`=0 and `lowD`=min(dt, fs), and deassert `pwm_reset`.
- RAMP:
  - Each boundary: `highD` ← min(`highD`+`RAMP_STEP`, dclamp).
  - Go to RUN on the boundary where the new `highD` equals dclamp.
  - If `duty_target` drops below the current `highD`, load dclamp at the boundary and go to RUN.
- RUN: each boundary, `highD` ← dclamp (increases and decreases apply in one step).
- `enable`=0 in RAMP or RUN:
  - Go to IDLE on the next cycle, without waiting for a boundary.
  - `pwm_reset`=1 and `highD`=`lowD`=0.
- FAULT entry:
  - `fault`=1 in any state has priority over `enable` and boundary updates.
  - Next cycle: FAULT, `pwm_reset`=1, `highD`=`lowD`=0, `fault_latched`=1.
- FAULT exit: go to IDLE only when `clear_fault`=1, `fault`=0 and `enable`=0 in the same cycle; otherwise stay in FAULT.
- Reset values: `highD`=`lowD`=`frequency_select`=0, `pwm_reset`=1, `period_start`=0, `fault_latched`=0, `state`=IDLE, mirror count 0.
- Reset mid-operation returns all outputs to their reset values asynchronously.

## Timing
- `enable` to first PWM period:
  - `enable` is sampled at edge N.
  - At N+1, `pwm_reset`=0 and the generator count is 0.
  - `period_start`=1 in cycle N+1.
- Boundary loads:
  - A value sampled when count==fs is visible on the outputs in the cycle where count==0.
  - That is a latency of 1 cycle, and the loaded value is constant for the whole period.
- `fault` to shutdown: 1 cycle (registered `pwm_reset`).
- Period length is fs+1 cycles, using the fs in force at the boundary that started the period.

## Configuration
- `DPWM_SOFTSTART_EN`
  - Defined: RAMP is present, as above.
  - Undefined: RAMP is removed, and IDLE goes directly to RUN with `highD`=dclamp (sampled from the entry-cycle inputs) loaded on entry. `RAMP_STEP` is unused.

## Structure
- Package `dpwm_pkg` holds:
  - the state encoding (IDLE=0, RAMP=1, RUN=2, FAULT=3);
  - the saturating min/add helper;
  - the default RESOLUTION constant.
- Sub-module `dpwm_period_tracker` contains the mirror counter, the fs computation, and the boundary and `period_start` outputs.
- FSM and duty registers live in the top module.

## Test plan
All scenarios use `freq_sel_in`=4086 (fs=9, period 10 cycles), `dead_time`=2, `RAMP_STEP`=1.
- Reset with `reset_n`=0, asserted mid-RUN → all outputs at reset values asynchronously; `pwm_reset`=1.
- `enable`↑ with `duty_target`=6, soft-start on → `highD` steps 0,1,…,6, one step per 10 cycles; `lowD`=`highD`+2; `state`=RUN in the period where `highD` first equals 6.
- `duty_target`=9 → `highD` saturates at 7 and `lowD`=9; `duty_target`=0 → `highD`=0 and `lowD`=2.
- In RUN, `duty_target` 6→3 while count=4 → `highD` stays 6 until the cycle after count==9, then 3.
- `fault`=1 during RAMP → next cycle FAULT, `pwm_reset`=1, `highD`=`lowD`=0; `clear_fault` with `enable`=1 → stays FAULT; `clear_fault` with `enable`=0 → IDLE.
- `DPWM_SOFTSTART_EN` undefined, `enable`↑ with `duty_target`=6 → `highD`=6 and `lowD`=8 from the first period; `state` goes IDLE→RUN.
